speed_ramp_controller: RTL

- Parametrised game-speed generator. Holds the dino/obstacle scroll speed as an unsigned fixed-point value.
- Raises the speed every `interval` counted cycles until it reaches a ceiling.
- Supports two ramp modes, run/pause gating, a game-logic restart, a level counter and a step strobe.
- Sits between the game-state FSM (run/pause/restart) and the scroll/obstacle movers, which consume `speed`.

---
 rtl/speed_ramp_controller.sv | 110 +++++++++++
 1 files changed

// File: rtl/speed_ramp_controller.sv
// Game-speed generator: raises a fixed-point scroll speed every `interval` counted
// cycles, clamping at MAX_SPEED, with linear or geometric ramp, pause and restart.
module speed_ramp_controller #(
    parameter int INT_BITS    = 12,
    parameter int FRAC_BITS   = 2,
    parameter int START_SPEED = 4,
    parameter int MAX_SPEED   = 46,
    parameter int RAMP_MODE   = 0,
    parameter int STEP        = 1,
    parameter int GEO_SHIFT   = 3,
    parameter int INTERVAL_W  = 32,
    parameter int LEVEL_W     = 8,
    localparam int W          = INT_BITS + FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  pause,
    input  logic                  restart,
    input  logic [INTERVAL_W-1:0] interval,
    output logic [W-1:0]          speed,
    output logic [LEVEL_W-1:0]    level,
    output logic                  step_pulse,
    output logic                  at_max
);

    localparam logic [W-1:0] START_V  = W'(START_SPEED);
    localparam logic [W-1:0] MAX_V    = W'(MAX_SPEED);
    localparam logic [W:0]   MAX_EXT  = (W+1)'(MAX_SPEED);
    localparam logic [W:0]   STEP_EXT = (W+1)'(STEP);
    localparam logic         START_AT_MAX = (START_SPEED == MAX_SPEED);

    logic [INTERVAL_W-1:0] timer_q, timer_d;
    logic [W-1:0]          speed_q, speed_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic                  step_q, step_d;
    logic                  at_max_q, at_max_d;

    logic                  cnt_en;
    logic [INTERVAL_W-1:0] eff_m1;
    logic                  expire;
    logic [W-1:0]          geo_shr;
    logic [W:0]            inc;
    logic [W:0]            sum;
    logic [W-1:0]          next_speed;

    always_comb begin
        cnt_en  = run & ~pause;
        // interval of 0 behaves as 1, so the last count index is 0 in both cases
        eff_m1  = (interval == '0) ? '0 : interval - INTERVAL_W'(1);
        expire  = cnt_en & (timer_q >= eff_m1);

        geo_shr = speed_q >> GEO_SHIFT;
        if (RAMP_MODE == 1)
            inc = (geo_shr == '0) ? (W+1)'(1) : {1'b0, geo_shr};
        else
            inc = STEP_EXT;

        // W+1 bit sum so a large increment clamps instead of wrapping
        sum        = {1'b0, speed_q} + inc;
        next_speed = (sum >= MAX_EXT) ? MAX_V : sum[W-1:0];
    end

    always_comb begin
        timer_d = timer_q;
        speed_d = speed_q;
        level_d = level_q;
        step_d  = 1'b0;

        if (restart) begin
            timer_d = '0;
            speed_d = START_V;
            level_d = '0;
        end else if (expire) begin
            timer_d = '0;
            if (speed_q != MAX_V) begin
                speed_d = next_speed;
                step_d  = 1'b1;
                if (level_q != {LEVEL_W{1'b1}})
                    level_d = level_q + LEVEL_W'(1);
            end
        end else if (cnt_en) begin
            timer_d = timer_q + INTERVAL_W'(1);
        end

        at_max_d = (speed_d == MAX_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            speed_q  <= START_V;
            level_q  <= '0;
            step_q   <= 1'b0;
            at_max_q <= START_AT_MAX;
        end else begin
            timer_q  <= timer_d;
            speed_q  <= speed_d;
            level_q  <= level_d;
            step_q   <= step_d;
            at_max_q <= at_max_d;
        end
    end

    assign speed      = speed_q;
    assign level      = level_q;
    assign step_pulse = step_q;
    assign at_max     = at_max_q;

endmodule
